// File: rtl/mc_conv_seq.sv
// Dual-slope ADC conversion sequencer: AZ / INT / DEINT phasing, BCD count,
// result latch with range flags, and the free-running digit-strobe scan.
module mc_conv_seq #(
  parameter int AZ_CYCLES  = 4000,
  parameter int INT_CYCLES = 2000,
  parameter int DEINT_MAX  = 4000,
  parameter int DS_WIDTH   = 20,
  parameter bit CONT       = 1'b1
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic       cmp,
  input  logic       pol_in,
  output logic       az_en,
  output logic       int_en,
  output logic       deint_en,
  output logic       ref_neg,
  output logic       busy,
  output logic       eoc,
  output logic [3:0] q,
  output logic [3:0] ds,
  output logic       pol,
  output logic       ovr,
  output logic       udr
);

  localparam int M1  = (AZ_CYCLES > INT_CYCLES) ? AZ_CYCLES : INT_CYCLES;
  localparam int M2  = (M1 > DEINT_MAX) ? M1 : DEINT_MAX;
  localparam int CW0 = $clog2(M2 + 1);
  // wide enough to hold the 1999 over-range threshold
  localparam int CW  = (CW0 < 12) ? 12 : CW0;
  localparam int DW  = $clog2(DS_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AZ, S_INT, S_DEINT, S_LATCH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_b3;
  logic [3:0]      r_b2, r_b1, r_b0;
  logic [1:0]      r_d3;
  logic [3:0]      r_d2, r_d1, r_d0;
  logic            r_polc, r_tmo;
  logic            r_pol, r_ovr, r_udr;
  logic [3:0]      r_ds;
  logic [DW-1:0]   r_dsc;
  logic            w_ovr, w_udr;

  always_comb begin
    w_next   = r_state;
    az_en    = 1'b0;
    int_en   = 1'b0;
    deint_en = 1'b0;
    ref_neg  = 1'b0;
    busy     = 1'b1;
    eoc      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (CONT || start) w_next = S_AZ;
      end
      S_AZ: begin
        az_en = 1'b1;
        if (r_cnt == CW'(AZ_CYCLES - 1)) w_next = S_INT;
      end
      S_INT: begin
        int_en = 1'b1;
        if (r_cnt == CW'(INT_CYCLES - 1)) w_next = S_DEINT;
      end
      S_DEINT: begin
        deint_en = 1'b1;
        ref_neg  = ~r_polc;
        if (!cmp || r_cnt == CW'(DEINT_MAX - 1)) w_next = S_LATCH;
      end
      S_LATCH: begin
        eoc    = 1'b1;
        w_next = CONT ? S_AZ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ovr = (r_cnt > CW'(1999)) | r_tmo;
  assign w_udr = (r_cnt < CW'(180)) & ~w_ovr;

  always_ff @(posedge clk) begin
    if (!R) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_b3    <= '0;
      r_b2    <= '0;
      r_b1    <= '0;
      r_b0    <= '0;
      r_d3    <= '0;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      r_polc  <= 1'b0;
      r_tmo   <= 1'b0;
      r_pol   <= 1'b0;
      r_ovr   <= 1'b0;
      r_udr   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_AZ: r_cnt <= (w_next == S_AZ) ? r_cnt + CW'(1) : '0;
        S_INT: begin
          if (w_next == S_INT) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt  <= '0;
            r_polc <= pol_in;
            r_tmo  <= 1'b0;
            r_b3   <= '0;
            r_b2   <= '0;
            r_b1   <= '0;
            r_b0   <= '0;
          end
        end
        S_DEINT: begin
          if (cmp) begin
            if (r_cnt == CW'(DEINT_MAX - 1)) begin
              r_tmo <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
              if (r_b0 != 4'd9) begin
                r_b0 <= r_b0 + 4'd1;
              end else begin
                r_b0 <= '0;
                if (r_b1 != 4'd9) begin
                  r_b1 <= r_b1 + 4'd1;
                end else begin
                  r_b1 <= '0;
                  if (r_b2 != 4'd9) begin
                    r_b2 <= r_b2 + 4'd1;
                  end else begin
                    r_b2 <= '0;
                    r_b3 <= r_b3 + 2'd1;
                  end
                end
              end
            end
          end
        end
        S_LATCH: begin
          r_cnt <= '0;
          r_d3  <= r_b3;
          r_d2  <= r_b2;
          r_d1  <= r_b1;
          r_d0  <= r_b0;
          r_pol <= r_polc;
          r_ovr <= w_ovr;
          r_udr <= w_udr;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // scan free-runs regardless of conversion state
  always_ff @(posedge clk) begin
    if (!R) begin
      r_ds  <= 4'b1000;
      r_dsc <= '0;
    end else if (r_dsc == DW'(DS_WIDTH - 1)) begin
      r_dsc <= '0;
      r_ds  <= {r_ds[0], r_ds[3:1]};
    end else begin
      r_dsc <= r_dsc + DW'(1);
    end
  end

  always_comb begin
    q = 4'd0;
    unique case (1'b1)
      r_ds[3]: q = {2'b00, r_d3};
      r_ds[2]: q = r_d2;
      r_ds[1]: q = r_d1;
      r_ds[0]: q = r_d0;
      default: q = 4'd0;
    endcase
  end

  assign ds  = r_ds;
  assign pol = r_pol;
  assign ovr = r_ovr;
  assign udr = r_udr;

endmodule

// File: tb/tb_mc_conv_seq.sv
// Scoreboard bench: one single-shot instance and one free-running instance,
// both checked against an arithmetic model of the conversion result.
module tb_mc_conv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int res;
    int len;
    bit pol;
    bit ovr;
    bit udr;
  } exp_t;

  function automatic exp_t model(input int n, input bit p, input int dm);
    exp_t e;
    e.len = (n >= dm) ? dm : n + 1;
    e.res = (n >= dm) ? dm - 1 : n;
    e.ovr = (e.res > 1999) || (n >= dm);
    e.udr = (e.res < 180) && !e.ovr;
    e.pol = p;
    return e;
  endfunction

  // ---------------- instance A: single-shot
  logic       a_R, a_start, a_cmp, a_pol_in;
  logic       a_az, a_int, a_deint, a_ref, a_busy, a_eoc;
  logic [3:0] a_q, a_ds;
  logic       a_pol, a_ovr, a_udr;

  mc_conv_seq #(
    .AZ_CYCLES(8), .INT_CYCLES(20), .DEINT_MAX(4000),
    .DS_WIDTH(3), .CONT(1'b0)
  ) u_a (
    .clk(clk), .R(a_R), .start(a_start), .cmp(a_cmp), .pol_in(a_pol_in),
    .az_en(a_az), .int_en(a_int), .deint_en(a_deint), .ref_neg(a_ref),
    .busy(a_busy), .eoc(a_eoc), .q(a_q), .ds(a_ds),
    .pol(a_pol), .ovr(a_ovr), .udr(a_udr)
  );

  // ---------------- instance B: free-running
  logic       b_R, b_start, b_cmp, b_pol_in;
  logic       b_az, b_int, b_deint, b_ref, b_busy, b_eoc;
  logic [3:0] b_q, b_ds;
  logic       b_pol, b_ovr, b_udr;

  mc_conv_seq #(
    .AZ_CYCLES(10), .INT_CYCLES(10), .DEINT_MAX(40),
    .DS_WIDTH(3), .CONT(1'b1)
  ) u_b (
    .clk(clk), .R(b_R), .start(b_start), .cmp(b_cmp), .pol_in(b_pol_in),
    .az_en(b_az), .int_en(b_int), .deint_en(b_deint), .ref_neg(b_ref),
    .busy(b_busy), .eoc(b_eoc), .q(b_q), .ds(b_ds),
    .pol(b_pol), .ovr(b_ovr), .udr(b_udr)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   na = 0, ka = 0, nb = 0, kb = 0, bi = 0;
  bit   pa = 1'b0;
  int   a_done = 0, a_eocs = 0, b_eocs = 0;
  int   tb_t = 0;

  task automatic scan_digits(input bit sel, input int res, input string nm);
    int got[4];
    int ex[4];
    logic [3:0] dsv, qv;
    ex[3] = res / 1000;
    ex[2] = (res / 100) % 10;
    ex[1] = (res / 10) % 10;
    ex[0] = res % 10;
    for (int i = 0; i < 4; i++) got[i] = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      dsv = sel ? b_ds : a_ds;
      qv  = sel ? b_q : a_q;
      for (int i = 0; i < 4; i++) if (dsv[i]) got[i] = int'(qv);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_digit%0d", nm, 4 - i), got[i], ex[i]);
  endtask

  // A: comparator stimulus, cmp=1 for na DEINT cycles
  initial begin
    a_cmp = 1'b0;
    forever begin
      @(negedge clk);
      if (!a_R) begin
        ka = 0;
      end else if (a_deint) begin
        a_cmp = (ka < na);
        ka++;
      end else begin
        if (!a_eoc) ka = 0;
        a_cmp = 1'($urandom_range(0, 1));
      end
    end
  end

  // A: monitor / scoreboard
  initial begin
    int azc = 0, intc = 0;
    logic refv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!a_R) begin
        azc = 0;
        intc = 0;
      end else begin
        if (a_az) azc++;
        if (a_int) intc++;
        if (a_deint) refv = a_ref;
        if (a_eoc) begin
          a_eocs++;
          if (qa.size() == 0) begin
            chk("a_unexpected_eoc", 1, 0);
          end else begin
            e = qa.pop_front();
            chk("a_az_len", azc, 8);
            chk("a_int_len", intc, 20);
            chk("a_deint_len", ka, e.len);
            chk("a_ref_neg", refv, !e.pol);
            @(negedge clk);
            chk("a_eoc_1cyc", a_eoc, 0);
            chk("a_pol", a_pol, e.pol);
            chk("a_ovr", a_ovr, e.ovr);
            chk("a_udr", a_udr, e.udr);
            scan_digits(1'b0, e.res, "a");
          end
          azc = 0;
          intc = 0;
          a_done++;
        end
      end
    end
  end

  // B: comparator and polarity stimulus; expectation pushed at DEINT entry
  initial begin
    int preset[4] = '{40, 0, 39, 45};
    b_cmp = 1'b0;
    b_pol_in = 1'b1;
    forever begin
      @(negedge clk);
      if (!b_R) begin
        kb = 0;
        bi = 0;
      end else if (b_deint) begin
        if (kb == 0) begin
          nb = (bi < 4) ? preset[bi] : int'($urandom_range(0, 45));
          bi++;
          qb.push_back(model(nb, b_pol_in, 40));
        end
        b_cmp = (kb < nb);
        kb++;
      end else begin
        if (!b_eoc) kb = 0;
        b_cmp = 1'($urandom_range(0, 1));
      end
      if (b_eoc) b_pol_in = 1'($urandom_range(0, 1));
    end
  end

  // B: monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_R && b_eoc) begin
        b_eocs++;
        if (qb.size() == 0) begin
          chk("b_unexpected_eoc", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_deint_len", kb, e.len);
          @(negedge clk);
          chk("b_eoc_1cyc", b_eoc, 0);
          chk("b_latch_to_az", b_az, 1);
          chk("b_pol", b_pol, e.pol);
          chk("b_ovr", b_ovr, e.ovr);
          chk("b_udr", b_udr, e.udr);
          scan_digits(1'b1, e.res, "b");
        end
      end
    end
  end

  // B: strobe position from elapsed cycles since reset
  initial forever begin
    @(posedge clk);
    if (!b_R) tb_t = 0;
    else tb_t++;
  end

  initial begin
    logic [3:0] ex;
    logic [3:0] one = 4'b1000;
    forever begin
      @(negedge clk);
      ex = one >> ((tb_t / 3) % 4);
      chk("b_ds_scan", b_ds, ex);
    end
  end

  task automatic conv_a(input int n, input bit p, input bit glitch);
    int d0;
    int bc;
    d0 = a_done;
    na = n;
    pa = p;
    a_pol_in = p;
    qa.push_back(model(n, p, 4000));
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (10) @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
    end
    for (int c = 0; c < n + 300 && a_done == d0; c++) @(negedge clk);
    chk($sformatf("a_conv_done_n%0d", n), a_done - d0, 1);
    bc = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_busy) bc++;
    end
    chk("a_no_requeue", bc, 0);
  endtask

  initial begin
    int bc;
    int e0;
    a_R = 1'b0;
    a_start = 1'b0;
    a_pol_in = 1'b0;
    b_R = 1'b0;
    b_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_enables", {a_az, a_int, a_deint, a_ref}, 0);
    chk("rst_eoc", a_eoc, 0);
    chk("rst_flags", {a_pol, a_ovr, a_udr}, 0);
    chk("rst_ds", a_ds, 4'b1000);
    chk("rst_q", a_q, 0);
    chk("rst_b_busy", b_busy, 0);
    a_R = 1'b1;
    b_R = 1'b1;
    bc = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_busy) bc++;
    end
    chk("idle_hold", bc, 0);

    conv_a(1234, 1'b1, 1'b1);

    // abort mid-DEINT
    e0 = a_eocs;
    na = 500;
    a_pol_in = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 0; c < 100 && !a_deint; c++) @(negedge clk);
    chk("abort_reached_deint", a_deint, 1);
    repeat (100) @(negedge clk);
    a_R = 1'b0;
    @(negedge clk);
    chk("abort_busy", a_busy, 0);
    chk("abort_deint", a_deint, 0);
    chk("abort_flags", {a_pol, a_ovr, a_udr}, 0);
    a_R = 1'b1;
    scan_digits(1'b0, 0, "abort");
    chk("abort_no_eoc", a_eocs - e0, 0);

    conv_a(0, 1'b1, 1'b0);
    conv_a(179, 1'b1, 1'b0);
    conv_a(180, 1'b1, 1'b0);
    conv_a(1999, 1'b0, 1'b0);
    conv_a(2000, 1'b1, 1'b0);
    conv_a(4100, 1'b0, 1'b0);
    conv_a(int'($urandom_range(0, 3999)), 1'($urandom_range(0, 1)), 1'b0);
    conv_a(int'($urandom_range(0, 3999)), 1'($urandom_range(0, 1)), 1'b0);

    chk("a_pending", qa.size(), 0);
    for (int c = 0; c < 5000 && b_eocs < 30; c++) @(negedge clk);
    chk("b_conversions", (b_eocs >= 30) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_conv_seq.md
Name: mc_conv_seq

Overview:
- Conversion sequencer for the MC14433-style 3½-digit dual-slope ADC.
- Steps the analog front end through auto-zero, signal integration and reference de-integration, and counts de-integration clocks in BCD.
- Latches the result with polarity, over-range and under-range flags.
- Drives the multiplexed digit-strobe scan read by the digit shift/latch chain.

Parameters:
- AZ_CYCLES, 4000, auto-zero phase length in clk cycles (≥2)
- INT_CYCLES, 2000, signal-integrate phase length in clk cycles (≥2)
- DEINT_MAX, 4000, de-integration timeout in clk cycles (≤4000, ≥2)
- DS_WIDTH, 20, clk cycles each digit strobe stays high (≥1)
- CONT, 1, 1 = free-running conversions; 0 = one conversion per start

Ports:
- clk, input, 1, system clock; all state changes on rising edge
- R, input, 1, synchronous active-low reset
- start, input, 1, begins a conversion from IDLE; ignored while busy
- cmp, input, 1, integrator comparator, synchronous to clk; 1 = integrator not yet back to zero
- pol_in, input, 1, input polarity (1 = positive), valid during INT
- az_en, output, 1, auto-zero switch enable
- int_en, output, 1, signal-integrate switch enable
- deint_en, output, 1, reference de-integrate switch enable
- ref_neg, output, 1, reference polarity select; equals inverse of sampled polarity during DEINT
- busy, output, 1, high in any state except IDLE
- eoc, output, 1, one-cycle end-of-conversion pulse
- q, output, 4, multiplexed BCD digit for the active strobe
- ds, output, 4, one-hot digit strobe; ds[3] = DS1 (MSD) … ds[0] = DS4 (LSD)
- pol, output, 1, latched polarity
- ovr, output, 1, latched over-range (result > 1999 or timeout)
- udr, output, 1, latched under-range (result < 180)

Behaviour:
- Reset (R=0 at a clk edge):
  - State goes to IDLE. All counters clear.
  - az_en, int_en, deint_en, ref_neg, busy, eoc, pol, ovr and udr are 0.
  - Result digits clear, so q=0. ds=4'b1000 with the strobe counter at 0.
  - Reset mid-conversion aborts it: no eoc, latched result is cleared.
- States:
  - IDLE: all analog enables 0. With CONT=1, goes to AZ on the first cycle after reset release. With CONT=0, goes to AZ on the cycle after start=1 is sampled.
  - AZ: az_en=1 for exactly AZ_CYCLES cycles, then INT.
  - INT: int_en=1 for exactly INT_CYCLES cycles. pol_in is captured into a polarity register on the last INT cycle, then DEINT.
  - DEINT: deint_en=1, ref_neg = ~captured polarity. The BCD count (thousands digit 0–3, three digits 0–9) starts at 0 on entry. Each DEINT cycle with cmp=1 increments the count, with decimal carry 9→0.
    - The first cycle with cmp=0 goes to LATCH; the result is the number of preceding cmp=1 DEINT cycles, N.
    - If cmp=1 on the cycle where the count equals DEINT_MAX-1, go to LATCH with the result saturated at DEINT_MAX-1 and a timeout flag set.
  - LATCH: one cycle; analog enables 0.
    - Result, pol, ovr = (result > 1999) | timeout, and udr = (result < 180) & ~ovr are loaded on this edge.
    - eoc=1 for exactly this cycle.
    - Next state is AZ if CONT=1, else IDLE.
- busy is 1 in AZ, INT, DEINT and LATCH.
- Exactly one of az_en, int_en and deint_en is high in AZ, INT and DEINT; none is high in IDLE or LATCH.
- start while busy=1 is ignored and not queued.
- Digit scan:
  - Runs continuously after reset, independent of conversion state.
  - ds rotates 1000→0100→0010→0001→1000, each value held DS_WIDTH cycles.
  - q = {2'b00, thousands} while ds[3]; hundreds while ds[2]; tens while ds[1]; units while ds[0].
  - Display registers change only at LATCH, so q may change mid-strobe.
- The whole design is synchronous to clk; no combinational path from cmp to any output.

Test Plan:
- Reset/idle: R=0 for 3 cycles, CONT=0 → all enables, busy, eoc, ovr and udr are 0; ds=1000, q=0; start held 0 for 100 cycles → state stays IDLE.
- Nominal conversion: AZ=8, INT=20, DEINT_MAX=4000, CONT=0, pol_in=1, cmp=1 for 1234 DEINT cycles then 0 → az_en high 8 cycles, int_en high 20, deint_en high 1235 (1234 counting plus the terminating cmp=0 cycle); eoc pulses once; q reads 1,2,3,4 on DS1..DS4; pol=1, ovr=0, udr=0, ref_neg=0 during DEINT.
- Boundaries: results 0 (cmp=0 on first DEINT cycle), 179, 180, 1999 and 2000 → udr=1,1,0,0,0 and ovr=0,0,0,0,1; pol_in=0 → pol=0, ref_neg=1.
- Timeout: DEINT_MAX=40, cmp stuck at 1 → DEINT lasts 40 cycles, result 39, ovr=1, eoc pulses.
- Abort and start handling: R=0 mid-DEINT → next cycle IDLE, no eoc, result cleared; start pulses during AZ and INT → ignored, single conversion only.
- Free-run and scan: CONT=1, DS_WIDTH=3 → back-to-back conversions with LATCH→AZ in one cycle and eoc once per conversion; ds period is 12 cycles, unaffected by conversion state.
